// File: rtl/arbitro_escrita_banco_if.sv
// Handshake bundle between the two writeback sources and the register-file write port.
// With ARB_CONTAGEM_EN defined the bundle also carries the conflict counter.
interface arbitro_escrita_banco_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
`ifdef ARB_CONTAGEM_EN
    ,
    parameter int CNT_W  = 16
`endif
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_end;
    logic [DATA_W-1:0] a_dado;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_end;
    logic [DATA_W-1:0] b_dado;
    logic              b_ready;
    logic              wren;
    logic [ADDR_W-1:0] end_reg_d;
    logic [DATA_W-1:0] data_in;
    logic              ocupado;
`ifdef ARB_CONTAGEM_EN
    logic [CNT_W-1:0]  conflitos;

    modport slave (
        input  a_valid, a_end, a_dado, b_valid, b_end, b_dado,
        output a_ready, b_ready, wren, end_reg_d, data_in, ocupado,
        output conflitos
    );
    modport master (
        output a_valid, a_end, a_dado, b_valid, b_end, b_dado,
        input  a_ready, b_ready, wren, end_reg_d, data_in, ocupado,
        input  conflitos
    );
`else
    modport slave (
        input  a_valid, a_end, a_dado, b_valid, b_end, b_dado,
        output a_ready, b_ready, wren, end_reg_d, data_in, ocupado
    );
    modport master (
        output a_valid, a_end, a_dado, b_valid, b_end, b_dado,
        input  a_ready, b_ready, wren, end_reg_d, data_in, ocupado
    );
`endif
endinterface

// File: rtl/arbitro_escrita_banco.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B).
// Optional conflict counter enabled by defining ARB_CONTAGEM_EN.
module arbitro_escrita_banco #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
`ifdef ARB_CONTAGEM_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                     clock,
    input  logic                     reset_n,
    arbitro_escrita_banco_if.slave   bus
);
    logic              a_full_q, a_full_d;
    logic [ADDR_W-1:0] a_end_q, a_end_d;
    logic [DATA_W-1:0] a_dado_q, a_dado_d;
    logic              b_full_q, b_full_d;
    logic [ADDR_W-1:0] b_end_q, b_end_d;
    logic [DATA_W-1:0] b_dado_q, b_dado_d;
    logic              ptr_q, ptr_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              grant_a, grant_b;
    logic              a_rdy, b_rdy;

    // ptr_q == 0 favours A on a tie, 1 favours B
    always_comb begin
        grant_a = a_full_q & (!b_full_q | !ptr_q);
        grant_b = b_full_q & (!a_full_q | ptr_q);
        a_rdy   = !a_full_q | grant_a;
        b_rdy   = !b_full_q | grant_b;
    end

    always_comb begin
        a_full_d = a_full_q & !grant_a;
        a_end_d  = a_end_q;
        a_dado_d = a_dado_q;
        b_full_d = b_full_q & !grant_b;
        b_end_d  = b_end_q;
        b_dado_d = b_dado_q;
        ptr_d    = ptr_q;
        wren_d   = 1'b0;
        end_d    = end_q;
        data_d   = data_q;
        if (bus.a_valid & a_rdy) begin
            a_full_d = 1'b1;
            a_end_d  = bus.a_end;
            a_dado_d = bus.a_dado;
        end
        if (bus.b_valid & b_rdy) begin
            b_full_d = 1'b1;
            b_end_d  = bus.b_end;
            b_dado_d = bus.b_dado;
        end
        if (a_full_q & b_full_q)
            ptr_d = grant_a;
        unique case (1'b1)
            grant_a: begin
                end_d  = a_end_q;
                data_d = a_dado_q;
                wren_d = |a_end_q;
            end
            grant_b: begin
                end_d  = b_end_q;
                data_d = b_dado_q;
                wren_d = |b_end_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_full_q <= 1'b0;
            a_end_q  <= '0;
            a_dado_q <= '0;
            b_full_q <= 1'b0;
            b_end_q  <= '0;
            b_dado_q <= '0;
            ptr_q    <= 1'b0;
            wren_q   <= 1'b0;
            end_q    <= '0;
            data_q   <= '0;
        end else begin
            a_full_q <= a_full_d;
            a_end_q  <= a_end_d;
            a_dado_q <= a_dado_d;
            b_full_q <= b_full_d;
            b_end_q  <= b_end_d;
            b_dado_q <= b_dado_d;
            ptr_q    <= ptr_d;
            wren_q   <= wren_d;
            end_q    <= end_d;
            data_q   <= data_d;
        end
    end

    assign bus.a_ready   = a_rdy;
    assign bus.b_ready   = b_rdy;
    assign bus.wren      = wren_q;
    assign bus.end_reg_d = end_q;
    assign bus.data_in   = data_q;
    assign bus.ocupado   = a_full_q | b_full_q | wren_q;

`ifdef ARB_CONTAGEM_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (a_full_q & b_full_q & ~&cnt_q)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign bus.conflitos = cnt_q;
`endif
endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// Directed bench for arbitro_escrita_banco: reset, single write, ties,
// streaming, zero address and reset during operation.
module tb_arbitro_escrita_banco;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    arbitro_escrita_banco_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    arbitro_escrita_banco #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    task automatic drv_a(input logic [AW-1:0] e, input logic [DW-1:0] d);
        bus.a_valid = 1'b1;
        bus.a_end   = e;
        bus.a_dado  = d;
    endtask

    task automatic drv_b(input logic [AW-1:0] e, input logic [DW-1:0] d);
        bus.b_valid = 1'b1;
        bus.b_end   = e;
        bus.b_dado  = d;
    endtask

    logic [AW-1:0] le [0:31];
    logic [DW-1:0] ld [0:31];
    int   ia, ib, nlog, first, last;
    logic acc_a, acc_b, seen;

    initial begin
        rst_n = 1'b0;
        bus.a_valid = 1'b0; bus.a_end = '0; bus.a_dado = '0;
        bus.b_valid = 1'b0; bus.b_end = '0; bus.b_dado = '0;
        repeat (2) @(negedge clk);

        chk("rst_wren", bus.wren, 0);
        chk("rst_end", bus.end_reg_d, 0);
        chk("rst_data", bus.data_in, 0);
        chk("rst_a_ready", bus.a_ready, 1);
        chk("rst_b_ready", bus.b_ready, 1);
        chk("rst_ocupado", bus.ocupado, 0);
`ifdef ARB_CONTAGEM_EN
        chk("rst_conflitos", bus.conflitos, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // single write from A
        drv_a(5'd5, 32'hDEADBEEF);
        chk("single_a_ready", bus.a_ready, 1);
        @(negedge clk);
        idle();
        chk("single_wren_early", bus.wren, 0);
        chk("single_ocupado", bus.ocupado, 1);
        @(negedge clk);
        chk("single_wren", bus.wren, 1);
        chk("single_end", bus.end_reg_d, 5);
        chk("single_data", bus.data_in, 32'hDEADBEEF);
        @(negedge clk);
        chk("single_wren_off", bus.wren, 0);
        chk("single_end_hold", bus.end_reg_d, 5);
        chk("single_idle", bus.ocupado, 0);

        // tie with pointer on A
        drv_a(5'd3, 32'h11);
        drv_b(5'd3, 32'h22);
        @(negedge clk);
        idle();
        chk("tie1_wren_early", bus.wren, 0);
        chk("tie1_a_ready", bus.a_ready, 1);
        chk("tie1_b_ready", bus.b_ready, 0);
        @(negedge clk);
        chk("tie1_first", {bus.wren, bus.end_reg_d, bus.data_in},
            {1'b1, 5'd3, 32'h11});
        chk("tie1_b_ready2", bus.b_ready, 1);
        @(negedge clk);
        chk("tie1_second", {bus.wren, bus.end_reg_d, bus.data_in},
            {1'b1, 5'd3, 32'h22});
        @(negedge clk);
        chk("tie1_done", bus.wren, 0);

        // second tie: pointer now favours B
        drv_a(5'd4, 32'h33);
        drv_b(5'd4, 32'h44);
        @(negedge clk);
        idle();
        chk("tie2_b_ready", bus.b_ready, 1);
        chk("tie2_a_ready", bus.a_ready, 0);
        @(negedge clk);
        chk("tie2_first", {bus.wren, bus.end_reg_d, bus.data_in},
            {1'b1, 5'd4, 32'h44});
        @(negedge clk);
        chk("tie2_second", {bus.wren, bus.end_reg_d, bus.data_in},
            {1'b1, 5'd4, 32'h33});
        @(negedge clk);
        chk("tie2_done", bus.wren, 0);

        // zero address from B
        drv_b(5'd0, 32'hFFFFFFFF);
        chk("zero_b_ready", bus.b_ready, 1);
        @(negedge clk);
        idle();
        chk("zero_ocupado", bus.ocupado, 1);
        chk("zero_wren0", bus.wren, 0);
        @(negedge clk);
        chk("zero_wren1", bus.wren, 0);
        chk("zero_empty", bus.ocupado, 0);
        chk("zero_b_ready2", bus.b_ready, 1);

        // streaming: 8 words from each source
        ia = 0; ib = 0; nlog = 0; first = -1; last = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.wren) begin
                if (nlog < 32) begin
                    le[nlog] = bus.end_reg_d;
                    ld[nlog] = bus.data_in;
                end
                nlog++;
                if (first < 0) first = c;
                last = c;
            end
            bus.a_valid = (ia < 8);
            bus.a_end   = 5'(ia + 1);
            bus.a_dado  = 32'hA000_0000 + 32'(ia);
            bus.b_valid = (ib < 8);
            bus.b_end   = 5'(ib + 10);
            bus.b_dado  = 32'hB000_0000 + 32'(ib);
            #1;
            if (c >= 1 && c <= 15) begin
                chk($sformatf("stream_a_ready_c%0d", c), bus.a_ready, c % 2);
                chk($sformatf("stream_b_ready_c%0d", c), bus.b_ready,
                    (c + 1) % 2);
            end
            acc_a = bus.a_valid & bus.a_ready;
            acc_b = bus.b_valid & bus.b_ready;
            if (acc_a) ia++;
            if (acc_b) ib++;
        end
        idle();
        chk("stream_count", nlog, 16);
        chk("stream_span", last - first, 15);
        for (int i = 0; i < 16 && i < nlog; i++) begin
            if (i % 2 == 0)
                chk($sformatf("stream_w%0d", i), {le[i], ld[i]},
                    {5'(i / 2 + 1), 32'hA000_0000 + 32'(i / 2)});
            else
                chk($sformatf("stream_w%0d", i), {le[i], ld[i]},
                    {5'(i / 2 + 10), 32'hB000_0000 + 32'(i / 2)});
        end

        // reset while both buffers are busy; pointer favours B here
        @(negedge clk);
        drv_a(5'd7, 32'h77);
        drv_b(5'd8, 32'h88);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("midrst_wren_pre", {bus.wren, bus.end_reg_d}, {1'b1, 5'd8});
        chk("midrst_ocupado_pre", bus.ocupado, 1);
`ifdef ARB_CONTAGEM_EN
        chk("midrst_conflitos_nz", bus.conflitos != 0, 1);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wren", bus.wren, 0);
        chk("midrst_ocupado", bus.ocupado, 0);
        chk("midrst_data", bus.data_in, 0);
        chk("midrst_a_ready", bus.a_ready, 1);
`ifdef ARB_CONTAGEM_EN
        chk("midrst_conflitos", bus.conflitos, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | bus.wren;
        end
        chk("midrst_no_pending", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
